rvfi_trace_serializer: RTL
==========================

# rvfi_trace_serializer

Synthesizable RVFI trace transmitter: captures each retired-instruction packet from the core's RVFI port and serializes it as a fixed-format sequence of 32-bit words on a valid/ready stream. The stream goes to an off-chip trace port or a capture memory, where a host-side decoder rebuilds the same per-instruction log (pc, rd, memory access) that the simulation tracer prints. Sits beside the core, fed by the RVFI signals. Buffers bursts of retirements in a small record FIFO and reports drops explicitly instead of stalling the core.

## Interface
Parameters:
- DEPTH, 4, record FIFO depth in whole records; power of two, ≥2
- SYNC, 8'hA5, sync byte placed in header bits [31:24]

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- rvfi_valid  in  1  instruction retired this cycle
- rvfi_pc_rdata  in  32  pc of retired instruction
- rvfi_rd_addr  in  5  destination register (0 = none)
- rvfi_rd_wdata  in  32  rd write data
- rvfi_mem_addr  in  32  lower-index memory address
- rvfi_mem_rmask  in  4  lower-index read mask
- rvfi_mem_wmask  in  4  lower-index write mask
- rvfi_mem_rdata  in  32  lower-index read data
- rvfi_mem_wdata  in  32  lower-index write data
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts word
- tx_data  out  32  serialized word
- tx_last  out  1  last word of current record
- dropped_cnt  out  16  saturating count of dropped records

## Operation
- Record words, in order:
  - W0 header: [31:24] SYNC, [23:16] seq, [15:11] rd_addr, [10:7] rmask, [6:3] wmask, [2] 0, [1] ovf, [0] mem.
  - W1 pc. W2 rd_wdata. W3 mem_addr. W4 mem data.
- mem = |rmask or |wmask. W4 = rdata if |rmask, else wdata. W3/W4 are 0 when mem=0.
- seq: 8-bit counter, +1 on every rvfi_valid cycle whether the record is stored or dropped; wraps 255→0. A gap in seq on the host side identifies lost records.
- Capture: on a clock edge with rvfi_valid=1 and FIFO not full, push the record with the current seq.
- Full handling:
  - If rvfi_valid=1 and FIFO is full, drop the record.
  - Increment dropped_cnt, saturating at 16'hFFFF.
  - Set sticky ovf.
- ovf is written into the next pushed record's header, then cleared in the same cycle as that push.
- Full is evaluated on the count before the edge. A pop in the same cycle does not make room for a push at DEPTH.
- Serializer FSM:
  - IDLE: FIFO empty.
  - SEND: word index k = 0..N-1 over the head record.
  - A word transfers when tx_valid && tx_ready, then k increments.
  - On the transfer with tx_last=1: pop the head, set k=0, stay in SEND if another record is queued, else go to IDLE.
- Stream rules:
  - Once tx_valid=1, tx_valid, tx_data and tx_last stay stable until accepted.
  - tx_valid never depends combinationally on tx_ready.
- FIFO: circular buffer with pointers of log2(DEPTH)+1 bits. Wrap is handled via the MSB compare.

## Timing
- Reset values (first edge with rst_n=0):
  - tx_valid=0, tx_last=0, tx_data=0, dropped_cnt=0.
  - seq=0, ovf=0, FIFO empty, k=0, FSM in IDLE.
- Reset mid-record abandons that record; no partial words appear after reset.
- Latency: record pushed at edge t → W0 presented with tx_valid=1 in cycle t+1, when the FIFO was empty and the serializer idle.
- Throughput: one word per cycle with tx_ready held high, and no bubble between records. A 5-word record therefore takes 5 cycles.
- A push and a last-word pop in the same cycle are both performed; count is unchanged.
- rvfi_valid is sampled every cycle; back-to-back retirements are all captured until the FIFO is full.

## Configuration
- RVFI_TRACE_COMPRESS_EN defined: records with mem=0 are 3 words (W0..W2) with tx_last on W2. Records with mem=1 stay 5 words.
- Not defined: every record is 5 words with tx_last on W4. W3 and W4 are zero when mem=0.
- The header format is identical in both builds. The decoder selects the record length from header bit [0] when compression is enabled.

## Test plan
- Reset, then a single retire with pc=0x8000_0000, rd=5, wdata=0x1234, no mem, tx_ready=1 → W0=0xA500_2800 at t+1.
  - Then W1=0x8000_0000 and W2=0x0000_1234.
  - Compress build: tx_last on W2.
  - Non-compress build: W3=0, W4=0, tx_last on W4.
- Load with addr=0x100, rmask=4'hF, rdata=0xDEAD_BEEF, rd=0 → W0=0xA500_0781, W3=0x100, W4=0xDEAD_BEEF, tx_last on W4.
- tx_ready=0, DEPTH=4, 6 consecutive retires → dropped_cnt=2 and seq values 0–3 stored. Then tx_ready=1 → 4 records drain and tx_data stays stable while stalled. A 7th retire after draining carries ovf=1, seq=6; the following record has ovf=0.
- 300 retires with tx_ready=1 and random tx_ready stalls → seq wraps 255→0 and no record is lost.
- Assert rst_n=0 while W2 of a record is presented → tx_valid=0 next cycle. After release, the next retire yields W0 with seq=0 and dropped_cnt=0.

Source files
------------

// File: rtl/rvfi_trace_serializer.sv
// RVFI retirement trace serializer: record FIFO plus word-serializing stream FSM.
// Optional macro RVFI_TRACE_COMPRESS_EN shortens non-memory records to 3 words.
module rvfi_trace_serializer #(
  parameter int unsigned DEPTH = 4,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rvfi_valid,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  input  logic [31:0] rvfi_mem_rdata,
  input  logic [31:0] rvfi_mem_wdata,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  output logic        tx_last,
  output logic [15:0] dropped_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SEND} state_e;

  logic [DEPTH-1:0][4:0][31:0] rec_q;
  logic [4:0][31:0]            rec_new, head;
  logic [AW:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt;
  logic [2:0]                  k_q, k_d, last_idx;
  state_e                      state_q, state_d;
  logic [7:0]                  seq_q, seq_d;
  logic                        ovf_q, ovf_d;
  logic [15:0]                 drop_q, drop_d;
  logic                        full, empty, push, drop, pop, xfer, mem;

  assign cnt   = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = rvfi_valid && !full;
  assign drop  = rvfi_valid && full;

  // Record is fully formatted at capture so the output path is a plain mux.
  assign mem = (|rvfi_mem_rmask) || (|rvfi_mem_wmask);
  always_comb begin
    rec_new    = '0;
    rec_new[0] = {SYNC, seq_q, rvfi_rd_addr, rvfi_mem_rmask, rvfi_mem_wmask,
                  1'b0, ovf_q, mem};
    rec_new[1] = rvfi_pc_rdata;
    rec_new[2] = rvfi_rd_wdata;
    if (mem) begin
      rec_new[3] = rvfi_mem_addr;
      rec_new[4] = (|rvfi_mem_rmask) ? rvfi_mem_rdata : rvfi_mem_wdata;
    end
  end

  assign head = rec_q[rd_ptr_q[AW-1:0]];

`ifdef RVFI_TRACE_COMPRESS_EN
  assign last_idx = head[0][0] ? 3'd4 : 3'd2;
`else
  assign last_idx = 3'd4;
`endif

  assign tx_valid = (state_q == SEND);
  assign tx_data  = tx_valid ? head[k_q] : 32'h0;
  assign tx_last  = tx_valid && (k_q == last_idx);
  assign xfer     = tx_valid && tx_ready;
  assign pop      = xfer && tx_last;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: if (push || !empty) state_d = SEND;
      SEND: begin
        if (xfer) begin
          if (tx_last) begin
            k_d = 3'd0;
            if ((cnt == (AW+1)'(1)) && !push) state_d = IDLE;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? (AW+1)'(1) : (AW+1)'(0));
    rd_ptr_d = rd_ptr_q + (pop  ? (AW+1)'(1) : (AW+1)'(0));
    seq_d    = seq_q + (rvfi_valid ? 8'd1 : 8'd0);
    ovf_d    = ovf_q;
    if (push)      ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;
    drop_d   = drop_q;
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= 3'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      seq_q    <= 8'd0;
      ovf_q    <= 1'b0;
      drop_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) rec_q[wr_ptr_q[AW-1:0]] <= rec_new;
  end

  assign dropped_cnt = drop_q;
endmodule
